// File: rtl/cinco_pkg.sv
// cinco_pkg: shared definitions for the cinco RV32I decode stage.
//   - RV32I major opcode constants
//   - instr_class_e : coarse instruction class handed to execute
//   - imm_type_e    : immediate format selector for imm_gen
//   - opc_to_class / class_to_imm_type : opcode decode helpers
package cinco_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [3:0] {
        CLASS_LUI     = 4'd0,
        CLASS_AUIPC   = 4'd1,
        CLASS_JAL     = 4'd2,
        CLASS_JALR    = 4'd3,
        CLASS_BRANCH  = 4'd4,
        CLASS_LOAD    = 4'd5,
        CLASS_STORE   = 4'd6,
        CLASS_OP_IMM  = 4'd7,
        CLASS_OP      = 4'd8,
        CLASS_SYSTEM  = 4'd9,
        CLASS_ILLEGAL = 4'd10
    } instr_class_e;

    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_U    = 3'd3,
        IMM_J    = 3'd4,
        IMM_NONE = 3'd5
    } imm_type_e;

    // Map a major opcode to its class. FENCE (MISC_MEM) has no class in
    // this pipeline, so it is routed to the trap path like any unknown opcode.
    function automatic instr_class_e opc_to_class(input logic [6:0] opc);
        instr_class_e cls;
        case (opc)
            OPC_LUI:      cls = CLASS_LUI;
            OPC_AUIPC:    cls = CLASS_AUIPC;
            OPC_JAL:      cls = CLASS_JAL;
            OPC_JALR:     cls = CLASS_JALR;
            OPC_BRANCH:   cls = CLASS_BRANCH;
            OPC_LOAD:     cls = CLASS_LOAD;
            OPC_STORE:    cls = CLASS_STORE;
            OPC_OP_IMM:   cls = CLASS_OP_IMM;
            OPC_OP:       cls = CLASS_OP;
            OPC_SYSTEM:   cls = CLASS_SYSTEM;
            default:      cls = CLASS_ILLEGAL;
        endcase
        return cls;
    endfunction

    // Immediate format used by each class; R-type and illegal carry none.
    function automatic imm_type_e class_to_imm_type(input instr_class_e cls);
        imm_type_e t;
        case (cls)
            CLASS_LUI, CLASS_AUIPC:                            t = IMM_U;
            CLASS_JAL:                                         t = IMM_J;
            CLASS_JALR, CLASS_LOAD, CLASS_OP_IMM, CLASS_SYSTEM: t = IMM_I;
            CLASS_STORE:                                       t = IMM_S;
            CLASS_BRANCH:                                      t = IMM_B;
            default:                                           t = IMM_NONE;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// imm_gen: combinational RV32I immediate generator.
// Ports:
//   i_instr    [31:7] instruction word above the opcode field
//   i_imm_type [2:0]  imm_type_e format selector
//   o_imm      [31:0] sign-extended immediate (0 for IMM_NONE)
module imm_gen
    import cinco_pkg::*;
(
    input  logic [31:7] i_instr,
    input  logic [2:0]  i_imm_type,
    output logic [31:0] o_imm
);

    logic w_sign;
    assign w_sign = i_instr[31];

    // Reassemble the scattered immediate bits of each format.
    always_comb begin
        o_imm = 32'd0;
        case (i_imm_type)
            IMM_I:   o_imm = {{20{w_sign}}, i_instr[31:20]};
            IMM_S:   o_imm = {{20{w_sign}}, i_instr[31:25], i_instr[11:7]};
            IMM_B:   o_imm = {{19{w_sign}}, w_sign, i_instr[7], i_instr[30:25],
                              i_instr[11:8], 1'b0};
            IMM_U:   o_imm = {i_instr[31:12], 12'd0};
            IMM_J:   o_imm = {{11{w_sign}}, w_sign, i_instr[19:12], i_instr[20],
                              i_instr[30:21], 1'b0};
            default: o_imm = 32'd0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered ID stage of the cinco RV32I pipeline.
// Takes PC/instruction from fetch (valid/ready), drives the register-file
// read addresses combinationally, and latches decoded fields plus operands
// into a single-entry output register feeding execute.
// Ports:
//   clk, rst_n (async active-low), flush (kill held + incoming)
//   in_valid/in_ready/in_pc/in_instr     fetch side
//   rf_a1/rf_a2 -> rf_rd1/rf_rd2          register-file read port
//   wb_we/wb_a3/wb_wd3                    writeback (bypass + held refresh)
//   out_valid/out_ready/out_*             execute side
module decode_stage
    import cinco_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_instr,
    output logic [4:0]      rf_a1,
    output logic [4:0]      rf_a2,
    input  logic [XLEN-1:0] rf_rd1,
    input  logic [XLEN-1:0] rf_rd2,
    input  logic            wb_we,
    input  logic [4:0]      wb_a3,
    input  logic [XLEN-1:0] wb_wd3,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_rs1_val,
    output logic [XLEN-1:0] out_rs2_val,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [3:0]      out_class,
    output logic [2:0]      out_funct3,
    output logic            out_funct7b5,
    output logic            out_illegal
);

    // Output register
    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rs1_val;
    logic [XLEN-1:0] r_rs2_val;
    logic [XLEN-1:0] r_imm;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rs2;
    logic [4:0]      r_rd;
    logic [3:0]      r_class;
    logic [2:0]      r_funct3;
    logic            r_funct7b5;
    logic            r_illegal;

    // Decode of the incoming instruction
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [4:0]      w_rd;
    instr_class_e    w_class;
    logic [2:0]      w_imm_type;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic            w_accept;
    logic            w_stall;
    logic            w_refresh1;
    logic            w_refresh2;

    assign w_rs1      = in_instr[19:15];
    assign w_rs2      = in_instr[24:20];
    assign w_class    = opc_to_class(in_instr[6:0]);
    assign w_imm_type = class_to_imm_type(w_class);

    assign rf_a1    = w_rs1;
    assign rf_a2    = w_rs2;
    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready && !flush;

    // While execute stalls, a writeback to a held source register must be
    // folded into the held operand or the instruction would leave stale.
    assign w_stall    = r_valid && !out_ready;
    assign w_refresh1 = w_stall && wb_we && (wb_a3 != 5'd0) && (wb_a3 == r_rs1);
    assign w_refresh2 = w_stall && wb_we && (wb_a3 != 5'd0) && (wb_a3 == r_rs2);

    imm_gen u_imm_gen (
        .i_instr    (in_instr[31:7]),
        .i_imm_type (w_imm_type),
        .o_imm      (w_imm)
    );

    // Destination index: S/B-type have no rd, illegal must not write back.
    always_comb begin
        w_rd = in_instr[11:7];
        case (w_class)
            CLASS_STORE, CLASS_BRANCH, CLASS_ILLEGAL: w_rd = 5'd0;
            default:                                  w_rd = in_instr[11:7];
        endcase
    end

    // Operand select: the register file writes at the same edge we sample,
    // so a matching writeback is taken directly from wb_wd3.
    always_comb begin
        w_rs1_val = rf_rd1;
        w_rs2_val = rf_rd2;
        if (w_rs1 == 5'd0) begin
            w_rs1_val = '0;
        end else if (wb_we && (wb_a3 == w_rs1)) begin
            w_rs1_val = wb_wd3;
        end else begin
            w_rs1_val = rf_rd1;
        end
        if (w_rs2 == 5'd0) begin
            w_rs2_val = '0;
        end else if (wb_we && (wb_a3 == w_rs2)) begin
            w_rs2_val = wb_wd3;
        end else begin
            w_rs2_val = rf_rd2;
        end
    end

    // Valid flag: flush beats accept beats drain; otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    // Payload: load on accept, otherwise hold with writeback refresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_rs1_val  <= '0;
            r_rs2_val  <= '0;
            r_imm      <= '0;
            r_rs1      <= 5'd0;
            r_rs2      <= 5'd0;
            r_rd       <= 5'd0;
            r_class    <= 4'd0;
            r_funct3   <= 3'd0;
            r_funct7b5 <= 1'b0;
            r_illegal  <= 1'b0;
        end else if (w_accept) begin
            r_pc       <= in_pc;
            r_rs1_val  <= w_rs1_val;
            r_rs2_val  <= w_rs2_val;
            r_imm      <= w_imm;
            r_rs1      <= w_rs1;
            r_rs2      <= w_rs2;
            r_rd       <= w_rd;
            r_class    <= w_class;
            r_funct3   <= in_instr[14:12];
            r_funct7b5 <= in_instr[30];
            r_illegal  <= (w_class == CLASS_ILLEGAL);
        end else begin
            if (w_refresh1) begin
                r_rs1_val <= wb_wd3;
            end
            if (w_refresh2) begin
                r_rs2_val <= wb_wd3;
            end
        end
    end

    assign out_valid    = r_valid;
    assign out_pc       = r_pc;
    assign out_rs1_val  = r_rs1_val;
    assign out_rs2_val  = r_rs2_val;
    assign out_imm      = r_imm;
    assign out_rs1      = r_rs1;
    assign out_rs2      = r_rs2;
    assign out_rd       = r_rd;
    assign out_class    = r_class;
    assign out_funct3   = r_funct3;
    assign out_funct7b5 = r_funct7b5;
    assign out_illegal  = r_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: self-checking bench for decode_stage. A behavioural
// register file supplies rf_rd1/rf_rd2; a transaction-level model tracks
// which instruction sits in the output register. Held operands are checked
// against the architectural register value, which covers both bypass and
// hold-refresh without modelling either mechanism.
module tb_decode_stage;
    import cinco_pkg::*;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0400;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic [4:0]  rf_a1;
    logic [4:0]  rf_a2;
    logic [31:0] rf_rd1;
    logic [31:0] rf_rd2;
    logic        wb_we;
    logic [4:0]  wb_a3;
    logic [31:0] wb_wd3;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_rs1_val;
    logic [31:0] out_rs2_val;
    logic [31:0] out_imm;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic [3:0]  out_class;
    logic [2:0]  out_funct3;
    logic        out_funct7b5;
    logic        out_illegal;

    int total = 0;
    int bad   = 0;

    // Architectural register file and output-register model
    logic [31:0] regs [32];
    logic        m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_instr;

    assign rf_rd1 = regs[rf_a1];
    assign rf_rd2 = regs[rf_a2];

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .RESET_PC(TB_RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .wb_we(wb_we), .wb_a3(wb_a3), .wb_wd3(wb_wd3),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_imm(out_imm),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_class(out_class),
        .out_funct3(out_funct3), .out_funct7b5(out_funct7b5), .out_illegal(out_illegal)
    );

    function automatic logic [3:0] exp_class(input logic [31:0] w);
        case (w[6:0])
            7'h37: return CLASS_LUI;
            7'h17: return CLASS_AUIPC;
            7'h6F: return CLASS_JAL;
            7'h67: return CLASS_JALR;
            7'h63: return CLASS_BRANCH;
            7'h03: return CLASS_LOAD;
            7'h23: return CLASS_STORE;
            7'h13: return CLASS_OP_IMM;
            7'h33: return CLASS_OP;
            7'h73: return CLASS_SYSTEM;
            default: return CLASS_ILLEGAL;
        endcase
    endfunction

    function automatic logic [31:0] exp_imm(input logic [31:0] w);
        logic [3:0] c;
        logic [31:0] s;
        c = exp_class(w);
        s = {32{w[31]}};
        if (c == CLASS_LUI || c == CLASS_AUIPC) return {w[31:12], 12'd0};
        if (c == CLASS_JAL) return {s[31:20], w[19:12], w[20], w[30:21], 1'b0};
        if (c == CLASS_BRANCH) return {s[31:12], w[7], w[30:25], w[11:8], 1'b0};
        if (c == CLASS_STORE) return {s[31:12], w[31:25], w[11:7]};
        if (c == CLASS_JALR || c == CLASS_LOAD || c == CLASS_OP_IMM || c == CLASS_SYSTEM)
            return {s[31:12], w[31:20]};
        return 32'd0;
    endfunction

    function automatic logic [4:0] exp_rd(input logic [31:0] w);
        logic [3:0] c;
        c = exp_class(w);
        if (c == CLASS_STORE || c == CLASS_BRANCH || c == CLASS_ILLEGAL) return 5'd0;
        return w[11:7];
    endfunction

    task automatic drive(input logic fl, input logic iv, input logic [31:0] pc,
                         input logic [31:0] ins, input logic ordy, input logic we,
                         input logic [4:0] a3, input logic [31:0] wd);
        flush = fl; in_valid = iv; in_pc = pc; in_instr = ins;
        out_ready = ordy; wb_we = we; wb_a3 = a3; wb_wd3 = wd;
    endtask

    // One clock edge; afterwards update the model from the inputs that were
    // presented at that edge (they are still being driven).
    task automatic tick();
        logic rdy;
        rdy = !m_valid || out_ready;
        @(posedge clk);
        #1;
        if (flush) m_valid = 1'b0;
        else if (in_valid && rdy) begin
            m_valid = 1'b1; m_pc = in_pc; m_instr = in_instr;
        end else if (m_valid && out_ready) m_valid = 1'b0;
        if (wb_we && wb_a3 != 5'd0) regs[wb_a3] = wb_wd3;
    endtask

    task automatic idle_drain();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0);
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m_valid = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        #12;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        total++;
        if (out_pc !== TB_RESET_PC) begin bad++; $display("FAIL reset_pc: got %h want %h", out_pc, TB_RESET_PC); end
        total++;
        if ({out_rs1_val, out_rs2_val, out_imm, out_rs1, out_rs2, out_rd, out_class,
             out_funct3, out_funct7b5, out_illegal} !== 127'd0) begin
            bad++; $display("FAIL reset_fields: some out_* nonzero, imm=%h rd=%0d class=%0d", out_imm, out_rd, out_class);
        end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_addi();
        drive(1'b0, 1'b1, 32'h0000_0100, 32'h0050_0093, 1'b1, 1'b0, 5'd0, 32'd0);
        tick();
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL addi_valid: got %b want 1", out_valid); end
        total++;
        if (out_class !== CLASS_OP_IMM) begin bad++; $display("FAIL addi_class: got %0d want %0d", out_class, CLASS_OP_IMM); end
        total++;
        if (out_rd !== 5'd1) begin bad++; $display("FAIL addi_rd: got %0d want 1", out_rd); end
        total++;
        if (out_rs1_val !== 32'd0) begin bad++; $display("FAIL addi_rs1_val: got %h want 0", out_rs1_val); end
        total++;
        if (out_imm !== 32'h0000_0005) begin bad++; $display("FAIL addi_imm: got %h want 5", out_imm); end
        total++;
        if (out_pc !== 32'h0000_0100) begin bad++; $display("FAIL addi_pc: got %h want 100", out_pc); end
        idle_drain();
    endtask

    task automatic test_store();
        regs[2] = 32'h0000_0100;
        regs[5] = 32'h0000_00AB;
        drive(1'b0, 1'b1, 32'h0000_0104, 32'hFE51_2E23, 1'b1, 1'b0, 5'd0, 32'd0);
        #1;
        total++;
        if ({rf_a1, rf_a2} !== {5'd2, 5'd5}) begin bad++; $display("FAIL sw_rf_addr: got %0d/%0d want 2/5", rf_a1, rf_a2); end
        tick();
        total++;
        if (out_imm !== 32'hFFFF_FFFC) begin bad++; $display("FAIL sw_imm: got %h want fffffffc", out_imm); end
        total++;
        if (out_rd !== 5'd0) begin bad++; $display("FAIL sw_rd: got %0d want 0", out_rd); end
        total++;
        if (out_rs1_val !== 32'h100 || out_rs2_val !== 32'hAB) begin
            bad++; $display("FAIL sw_operands: got %h/%h want 100/ab", out_rs1_val, out_rs2_val);
        end
        total++;
        if (out_class !== CLASS_STORE) begin bad++; $display("FAIL sw_class: got %0d want %0d", out_class, CLASS_STORE); end
        idle_drain();
    endtask

    task automatic test_bypass();
        regs[2] = 32'h0000_0200;
        drive(1'b0, 1'b1, 32'h0000_0108, 32'h0011_01B3, 1'b1, 1'b1, 5'd2, 32'hDEAD_BEEF);
        tick();
        total++;
        if (out_rs1_val !== 32'hDEAD_BEEF) begin bad++; $display("FAIL bypass_rs1: got %h want deadbeef", out_rs1_val); end
        regs[2] = 32'h0000_0222;
        drive(1'b0, 1'b1, 32'h0000_010C, 32'h0011_01B3, 1'b1, 1'b1, 5'd0, 32'hDEAD_BEEF);
        tick();
        total++;
        if (out_rs1_val !== 32'h0000_0222) begin bad++; $display("FAIL bypass_x0: got %h want 222", out_rs1_val); end
        idle_drain();
    endtask

    task automatic test_stall_refresh();
        regs[1] = 32'h0000_1111;
        regs[2] = 32'h0000_2222;
        drive(1'b0, 1'b1, 32'h0000_0110, 32'h0011_01B3, 1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        total++;
        if (out_valid !== 1'b1 || out_rs2_val !== 32'h1111) begin
            bad++; $display("FAIL stall_load: got valid=%b rs2=%h want 1/1111", out_valid, out_rs2_val);
        end
        drive(1'b0, 1'b1, 32'h0000_0114, 32'h0050_0093, 1'b0, 1'b0, 5'd0, 32'd0);
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready1: got %b want 0", in_ready); end
        tick();
        drive(1'b0, 1'b1, 32'h0000_0114, 32'h0050_0093, 1'b0, 1'b1, 5'd1, 32'h1234_5678);
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready2: got %b want 0", in_ready); end
        tick();
        total++;
        if (out_rs2_val !== 32'h1234_5678) begin bad++; $display("FAIL stall_refresh: got %h want 12345678", out_rs2_val); end
        total++;
        if (out_rd !== 5'd3 || out_pc !== 32'h110) begin
            bad++; $display("FAIL stall_hold: got rd=%0d pc=%h want 3/110", out_rd, out_pc);
        end
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0);
        tick();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        drive(1'b0, 1'b1, 32'h0000_0200, 32'h0050_0093, 1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        drive(1'b1, 1'b1, 32'h0000_0204, 32'h0011_01B3, 1'b1, 1'b0, 5'd0, 32'd0);
        tick();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_kill: got %b want 0", out_valid); end
        idle_drain();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_no_ghost: got %b want 0", out_valid); end
    endtask

    task automatic test_illegal_reset();
        drive(1'b0, 1'b1, 32'h0000_0300, 32'h0000_0000, 1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        total++;
        if (out_illegal !== 1'b1 || out_class !== CLASS_ILLEGAL || out_rd !== 5'd0) begin
            bad++; $display("FAIL illegal_zero: got ill=%b class=%0d rd=%0d want 1/%0d/0", out_illegal, out_class, out_rd, CLASS_ILLEGAL);
        end
        total++;
        if (out_imm !== 32'd0) begin bad++; $display("FAIL illegal_imm: got %h want 0", out_imm); end
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_pc !== TB_RESET_PC) begin
            bad++; $display("FAIL async_reset: got valid=%b pc=%h want 0/%h", out_valid, out_pc, TB_RESET_PC);
        end
        m_valid = 1'b0;
        rst_n = 1'b1;
        idle_drain();
    endtask

    task automatic test_random();
        logic [6:0] legal [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
        logic [31:0] w;
        logic [6:0]  op;
        logic [31:0] e1, e2;
        for (int n = 0; n < 400; n++) begin
            w = $urandom;
            w[19:15] = 5'($urandom_range(0, 7));
            w[24:20] = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 9) < 8) begin
                w[6:0] = legal[$urandom_range(0, 9)];
            end else begin
                op = 7'($urandom);
                while (exp_class({25'd0, op}) != CLASS_ILLEGAL || op == 7'h0F) op = 7'($urandom);
                w[6:0] = op;
            end
            if ($urandom_range(0, 19) == 0) w = 32'd0;
            drive($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0, $urandom, w,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), $urandom);
            #1;
            total++;
            if (in_ready !== (!m_valid || out_ready)) begin
                bad++; $display("FAIL rnd_in_ready: got %b want %b", in_ready, !m_valid || out_ready);
            end
            tick();
            total++;
            if (out_valid !== m_valid) begin bad++; $display("FAIL rnd_valid: got %b want %b", out_valid, m_valid); end
            if (m_valid) begin
                e1 = regs[m_instr[19:15]];
                e2 = regs[m_instr[24:20]];
                total++;
                if (out_pc !== m_pc) begin bad++; $display("FAIL rnd_pc: got %h want %h", out_pc, m_pc); end
                total++;
                if (out_class !== exp_class(m_instr)) begin
                    bad++; $display("FAIL rnd_class: instr %h got %0d want %0d", m_instr, out_class, exp_class(m_instr));
                end
                total++;
                if (out_imm !== exp_imm(m_instr)) begin
                    bad++; $display("FAIL rnd_imm: instr %h got %h want %h", m_instr, out_imm, exp_imm(m_instr));
                end
                total++;
                if (out_rd !== exp_rd(m_instr)) begin
                    bad++; $display("FAIL rnd_rd: instr %h got %0d want %0d", m_instr, out_rd, exp_rd(m_instr));
                end
                total++;
                if ({out_rs1, out_rs2, out_funct3, out_funct7b5} !== {m_instr[19:15], m_instr[24:20], m_instr[14:12], m_instr[30]}) begin
                    bad++; $display("FAIL rnd_fields: instr %h got rs1=%0d rs2=%0d f3=%0d f7b5=%b", m_instr, out_rs1, out_rs2, out_funct3, out_funct7b5);
                end
                total++;
                if (out_illegal !== (exp_class(m_instr) == CLASS_ILLEGAL)) begin
                    bad++; $display("FAIL rnd_illegal: instr %h got %b", m_instr, out_illegal);
                end
                total++;
                if (out_rs1_val !== e1) begin bad++; $display("FAIL rnd_rs1_val: got %h want %h", out_rs1_val, e1); end
                total++;
                if (out_rs2_val !== e2) begin bad++; $display("FAIL rnd_rs2_val: got %h want %h", out_rs2_val, e2); end
            end
        end
        idle_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        regs[0] = 32'd0;
        for (int i = 1; i < 32; i++) regs[i] = $urandom;
        m_pc = 32'd0;
        m_instr = 32'd0;
        test_reset();
        test_addi();
        test_store();
        test_bypass();
        test_stall_refresh();
        test_flush();
        test_illegal_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
